shift_ctrl: RTL and testbench
=============================

Name: shift_ctrl

Overview:
Sequencing controller for the parameterised parallel-load shift register. It accepts a parallel word over a valid/ready handshake and loads it into an internal shift_register instance. It then clocks the word out MSB-first as a framed serial stream with a bit counter, and signals completion. It sits between a parallel producer and a serial consumer, such as a link or test pin.

Parameters:
BIT_SIZE, 8, word width in bits; legal range 2..64.
CNT_W, $clog2(BIT_SIZE+1), bit-counter width; derived, never overridden.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rstn  input  1  synchronous active-low reset
i_valid  input  1  producer has a word on i_data
o_ready  output  1  controller can accept a word
i_data  input  BIT_SIZE  parallel word to transmit
i_fill  input  1  bit shifted into the LSB during shifting
i_abort  input  1  abandon the current frame
o_sdata  output  1  serial data bit, MSB first
o_sval  output  1  o_sdata valid this cycle
o_frame  output  1  high from accept until the end of DONE
o_done  output  1  one-cycle completion pulse
o_busy_cnt  output  CNT_W  bits already emitted in the current frame

Behaviour:
- Reset when rstn=0 at a clock edge:
  - state=IDLE; o_ready=1.
  - o_sval=0, o_sdata=0, o_frame=0, o_done=0, o_busy_cnt=0.
  - Shift register content cleared to 0.
  - Reset mid-frame discards the frame; no o_done is produced.
- States: IDLE, SHIFT, (PAR), DONE.
- IDLE:
  - o_ready=1.
  - An accept is i_valid&o_ready at edge k: internal load=1 and d=i_data; the register captures the word at edge k; the next state is SHIFT.
  - With i_valid=0 the controller stays in IDLE.
- SHIFT:
  - o_sval=1; o_sdata=q[BIT_SIZE-1].
  - Each edge: q <= {q[BIT_SIZE-2:0], i_fill}; o_busy_cnt increments.
  - The first bit is valid in cycle k+1; the last bit is valid in cycle k+BIT_SIZE.
  - When o_busy_cnt==BIT_SIZE-1 at an edge, the next state is DONE, or PAR with the optional feature.
- DONE:
  - o_done=1 for exactly one cycle (k+BIT_SIZE+1); o_sval=0.
  - o_busy_cnt returns to 0; the next state is IDLE.
  - o_ready returns in cycle k+BIT_SIZE+2. Throughput is one word per BIT_SIZE+2 cycles.
- Signals not acted on:
  - o_ready=0 outside IDLE; i_valid and i_data are ignored while busy (no queueing).
  - i_fill affects only the register content, never o_sdata within the current frame.
- i_abort:
  - Sampled in SHIFT/PAR only; ignored in IDLE and DONE.
  - Next state is IDLE; o_sval drops the next cycle; o_done is not asserted; the counter clears.
  - i_abort in the same cycle as the last bit: abort wins and no o_done is produced.
- o_frame = (state != IDLE).
- All outputs are registered or decoded from registered state only; there is no combinational path from i_valid to o_sval.

Optional Feature:
Macro SHIFT_CTRL_PARITY_EN.
- Defined:
  - At accept, even parity of i_data (XOR reduction) is latched.
  - A PAR state follows the last data bit for one cycle: o_sval=1, o_sdata=parity, o_busy_cnt=BIT_SIZE.
  - i_abort in PAR behaves as in SHIFT.
  - o_done moves to k+BIT_SIZE+2; throughput becomes BIT_SIZE+3 cycles.
- Undefined: no PAR state and no parity register; timing is as in Behaviour.

Decomposition:
- Shared package shift_ctrl_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PAR=2'd2, ST_DONE=2'd3.
  - Default BIT_SIZE.
- One sub-module: the existing shift_register (ports clk, load, Sin, d, q; parameter bit_size). Its load and d come from the controller; Sin is tied to i_fill.
- The FSM, counter and parity logic stay in shift_ctrl.

Test Plan:
- Single word: reset, then i_data=8'hA5 accepted at cycle 0 → o_sdata=1,0,1,0,0,1,0,1 with o_sval=1 in cycles 1–8; o_done=1 in cycle 9; o_ready=1 again in cycle 10.
- Back-to-back: i_valid held high with 8'hFF then 8'h00 → second accept at cycle 10; eight 1s then eight 0s; no bit lost or duplicated; i_data changes while busy are ignored.
- Abort: 8'h3C, i_abort=1 in cycle 3 → o_sval=0 from cycle 4; no o_done; o_ready=1 in cycle 4; the next word 8'h81 transmits correctly.
- Reset mid-frame: rstn=0 in cycle 5 → all outputs at reset values the next cycle; o_busy_cnt=0; no o_done.
- Fill independence: i_fill=1 throughout, data 8'h00 → eight 0s emitted; o_busy_cnt steps 0..7.
- Parity (macro defined): 8'hA5 → parity bit 0 in cycle 9, o_done in cycle 10; 8'h07 → parity bit 1.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared constants for the shift_ctrl sequencer: state encoding and default word width.
package shift_ctrl_pkg;

    localparam int DEF_BIT_SIZE = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_PAR   = ST_PAR,
        S_DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/shift_register.sv
// Parallel-load shift register: load captures d, otherwise shifts left taking Sin into the LSB.
module shift_register #(
    parameter int bit_size = 8
) (
    input  logic                clk,
    input  logic                load,
    input  logic                Sin,
    input  logic [bit_size-1:0] d,
    output logic [bit_size-1:0] q
);

    always_ff @(posedge clk) begin
        if (load) q <= d;
        else      q <= {q[bit_size-2:0], Sin};
    end

endmodule

// File: rtl/shift_ctrl.sv
// Word-to-serial sequencer: accepts a word, emits it MSB-first with a bit counter, then pulses done.
// Optional trailing even-parity bit when SHIFT_CTRL_PARITY_EN is defined.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int BIT_SIZE = DEF_BIT_SIZE,
    parameter int CNT_W    = $clog2(BIT_SIZE + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [BIT_SIZE-1:0] i_data,
    input  logic                i_fill,
    input  logic                i_abort,
    output logic                o_sdata,
    output logic                o_sval,
    output logic                o_frame,
    output logic                o_done,
    output logic [CNT_W-1:0]    o_busy_cnt
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sr_load;
    logic [BIT_SIZE-1:0] sr_d;
    logic [BIT_SIZE-1:0] sr_q;
`ifdef SHIFT_CTRL_PARITY_EN
    logic                parity_q, parity_d;
`endif

    // Sin is the fill bit; reset clears the register by forcing a load of zero.
    shift_register #(.bit_size(BIT_SIZE)) u_sr (
        .clk  (clk),
        .load (sr_load),
        .Sin  (i_fill),
        .d    (sr_d),
        .q    (sr_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_load = 1'b0;
        sr_d    = i_data;
`ifdef SHIFT_CTRL_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    sr_load = 1'b1;
                    state_d = S_SHIFT;
                    cnt_d   = '0;
`ifdef SHIFT_CTRL_PARITY_EN
                    parity_d = ^i_data;
`endif
                end
            end
            S_SHIFT: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(BIT_SIZE - 1)) begin
`ifdef SHIFT_CTRL_PARITY_EN
                    state_d = S_PAR;
                    cnt_d   = CNT_W'(BIT_SIZE);
`else
                    state_d = S_DONE;
                    cnt_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef SHIFT_CTRL_PARITY_EN
            S_PAR: begin
                state_d = i_abort ? S_IDLE : S_DONE;
                cnt_d   = '0;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!rstn) begin
            sr_load = 1'b1;
            sr_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SHIFT_CTRL_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rstn) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end
`endif

    // Every output decodes registered state only, so i_valid never reaches o_sval combinationally.
    always_comb begin
        o_ready    = (state_q == S_IDLE);
        o_frame    = (state_q != S_IDLE);
        o_done     = (state_q == S_DONE);
        o_busy_cnt = cnt_q;
        o_sval     = 1'b0;
        o_sdata    = 1'b0;
        if (state_q == S_SHIFT) begin
            o_sval  = 1'b1;
            o_sdata = sr_q[BIT_SIZE-1];
        end
`ifdef SHIFT_CTRL_PARITY_EN
        if (state_q == S_PAR) begin
            o_sval  = 1'b1;
            o_sdata = parity_q;
        end
`endif
    end

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl; serial bits are scored against an expected queue.
module tb_shift_ctrl;

    localparam int BS    = 8;
    localparam int CW    = $clog2(BS + 1);
`ifdef SHIFT_CTRL_PARITY_EN
    localparam int PARB  = 1;
`else
    localparam int PARB  = 0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_valid;
    logic          o_ready;
    logic [BS-1:0] i_data;
    logic          i_fill;
    logic          i_abort;
    logic          o_sdata;
    logic          o_sval;
    logic          o_frame;
    logic          o_done;
    logic [CW-1:0] o_busy_cnt;

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int exp_done = 0;
    logic [0:0] exp_q[$];

    shift_ctrl #(.BIT_SIZE(BS)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_fill     (i_fill),
        .i_abort    (i_abort),
        .o_sdata    (o_sdata),
        .o_sval     (o_sval),
        .o_frame    (o_frame),
        .o_done     (o_done),
        .o_busy_cnt (o_busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial scoreboard plus done-pulse counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_sval === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bit", 64'(o_sval), 64'd0);
            end else begin
                chk("serial_bit", 64'(o_sdata), 64'(exp_q.pop_front()));
            end
        end
        if (o_done === 1'b1) done_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (o_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("ready_timeout", 64'(o_ready), 64'd1);
    endtask

    task automatic push_word(input logic [BS-1:0] data, input int nbits, input bit with_par);
        for (int i = 0; i < nbits; i++) exp_q.push_back(data[BS-1-i]);
        if (with_par) exp_q.push_back(^data);
    endtask

    task automatic send_word(input logic [BS-1:0] data, input logic fill);
        wait_ready();
        i_valid = 1'b1;
        i_data  = data;
        i_fill  = fill;
        push_word(data, BS, PARB != 0);
        step();
        i_valid = 1'b0;
        for (int i = 0; i < BS; i++) begin
            chk("cnt", 64'(o_busy_cnt), 64'(i));
            chk("sval", 64'(o_sval), 64'd1);
            chk("ready_busy", 64'(o_ready), 64'd0);
            i_data = BS'($urandom_range(0, 255));
            step();
        end
`ifdef SHIFT_CTRL_PARITY_EN
        chk("par_cnt", 64'(o_busy_cnt), 64'(BS));
        chk("par_sval", 64'(o_sval), 64'd1);
        step();
`endif
        chk("done", 64'(o_done), 64'd1);
        chk("done_sval", 64'(o_sval), 64'd0);
        chk("done_frame", 64'(o_frame), 64'd1);
        chk("done_cnt", 64'(o_busy_cnt), 64'd0);
        exp_done++;
        step();
        chk("ready_back", 64'(o_ready), 64'd1);
        chk("done_low", 64'(o_done), 64'd0);
        chk("frame_low", 64'(o_frame), 64'd0);
    endtask

    initial begin
        int n;
        rstn    = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_fill  = 1'b0;
        i_abort = 1'b0;
        step();
        step();
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_sval", 64'(o_sval), 64'd0);
        chk("rst_sdata", 64'(o_sdata), 64'd0);
        chk("rst_frame", 64'(o_frame), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_cnt", 64'(o_busy_cnt), 64'd0);
        rstn = 1'b1;
        step();
        chk("idle_hold", 64'(o_frame), 64'd0);

        send_word(8'hA5, 1'b0);
        send_word(8'h07, 1'b0);

        // Back-to-back with i_valid held; busy-time i_data is junk.
        i_valid = 1'b1;
        i_data  = 8'hFF;
        push_word(8'hFF, BS, PARB != 0);
        step();
        n = 0;
        while (o_ready !== 1'b1 && n < 40) begin
            i_data = BS'($urandom_range(0, 255));
            step();
            n++;
        end
        chk("b2b_gap", 64'(n), 64'(BS + 1 + PARB));
        i_data = 8'h00;
        push_word(8'h00, BS, PARB != 0);
        step();
        i_valid = 1'b0;
        chk("b2b_second_busy", 64'(o_ready), 64'd0);
        exp_done += 2;
        wait_ready();

        // Abort in cycle 3: three bits emitted, then back to idle.
        i_valid = 1'b1;
        i_data  = 8'h3C;
        push_word(8'h3C, 3, 1'b0);
        step();
        i_valid = 1'b0;
        step();
        step();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("abort_sval", 64'(o_sval), 64'd0);
        chk("abort_ready", 64'(o_ready), 64'd1);
        chk("abort_cnt", 64'(o_busy_cnt), 64'd0);
        chk("abort_done", 64'(o_done), 64'd0);
        send_word(8'h81, 1'b0);

        // Abort together with the last data bit.
        i_valid = 1'b1;
        i_data  = 8'h5A;
        push_word(8'h5A, BS, 1'b0);
        step();
        i_valid = 1'b0;
        for (int i = 1; i < BS; i++) step();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("lastabort_sval", 64'(o_sval), 64'd0);
        chk("lastabort_done", 64'(o_done), 64'd0);
        chk("lastabort_ready", 64'(o_ready), 64'd1);

        // Reset in cycle 5: five bits emitted, reset values next cycle.
        i_valid = 1'b1;
        i_data  = 8'hC3;
        push_word(8'hC3, 5, 1'b0);
        step();
        i_valid = 1'b0;
        for (int i = 1; i < 5; i++) step();
        rstn = 1'b0;
        step();
        chk("mrst_ready", 64'(o_ready), 64'd1);
        chk("mrst_sval", 64'(o_sval), 64'd0);
        chk("mrst_sdata", 64'(o_sdata), 64'd0);
        chk("mrst_frame", 64'(o_frame), 64'd0);
        chk("mrst_done", 64'(o_done), 64'd0);
        chk("mrst_cnt", 64'(o_busy_cnt), 64'd0);
        rstn = 1'b1;
        step();

        send_word(8'h00, 1'b1);
        send_word(BS'($urandom_range(0, 255)), 1'b1);
        i_fill = 1'b0;
        step();
        step();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("done_count", 64'(done_seen), 64'(exp_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
